// File: rtl/raster_scan_ctrl.sv
// Bounding-box raster traversal: walks a triangle bbox row-major, stepping edge/depth
// accumulators per pixel. Optional RASTER_EARLY_REJECT_EN drops pixels with a negative edge.
`ifndef FX_TOTAL_BITS
`define FX_TOTAL_BITS 16
`endif

module raster_scan_ctrl #(
  parameter int XW = 12,
  parameter int YW = 12,
  parameter int EW = 2*`FX_TOTAL_BITS,
  parameter int ZW = 2*`FX_TOTAL_BITS,
  parameter int MW = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              tri_vld,
  output logic              tri_rdy,
  input  logic [XW-1:0]     tri_min_x,
  input  logic [XW-1:0]     tri_max_x,
  input  logic [YW-1:0]     tri_min_y,
  input  logic [YW-1:0]     tri_max_y,
  input  logic [3*EW-1:0]   tri_e,
  input  logic [3*EW-1:0]   tri_edx,
  input  logic [3*EW-1:0]   tri_edy,
  input  logic [ZW-1:0]     tri_z,
  input  logic [ZW-1:0]     tri_dzdx,
  input  logic [ZW-1:0]     tri_dzdy,
  input  logic [MW-1:0]     tri_meta,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [XW-1:0]     out_x,
  output logic [YW-1:0]     out_y,
  output logic [3*EW-1:0]   out_e,
  output logic [ZW-1:0]     out_z,
  output logic [MW-1:0]     out_meta,
  output logic              done,
  output logic [XW+YW-1:0]  px_count
);

  typedef enum logic [0:0] {IDLE = 1'b0, SCAN = 1'b1} state_t;

  state_t            state;
  logic [XW-1:0]     min_x_q, max_x_q, cur_x;
  logic [YW-1:0]     max_y_q, cur_y;
  logic [3*EW-1:0]   edx_q, edy_q, row_e, cur_e;
  logic [ZW-1:0]     dzdx_q, dzdy_q, row_z, cur_z;
  logic [MW-1:0]     meta_q;
  logic [XW+YW-1:0]  cnt;

  logic              slot_free;
  logic              last_col, last_row;
  logic              issue;
  logic              empty_box;
  logic [3*EW-1:0]   e_step_x, e_step_y;
  logic [XW+YW-1:0]  cnt_inc;

  assign slot_free = !out_vld || out_rdy;
  assign last_col  = (cur_x == max_x_q);
  assign last_row  = (cur_y == max_y_q);
  assign empty_box = (tri_min_x > tri_max_x) || (tri_min_y > tri_max_y);
  assign cnt_inc   = cnt + (XW+YW)'(issue);

`ifdef RASTER_EARLY_REJECT_EN
  assign issue = !(cur_e[EW-1] || cur_e[2*EW-1] || cur_e[3*EW-1]);
`else
  assign issue = 1'b1;
`endif

  // Lane-wise adds; each edge wraps independently modulo 2^EW.
  always_comb begin
    e_step_x = '0;
    e_step_y = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      e_step_x[i*EW +: EW] = cur_e[i*EW +: EW] + edx_q[i*EW +: EW];
      e_step_y[i*EW +: EW] = row_e[i*EW +: EW] + edy_q[i*EW +: EW];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tri_rdy  <= 1'b0;
      min_x_q  <= '0;
      max_x_q  <= '0;
      max_y_q  <= '0;
      cur_x    <= '0;
      cur_y    <= '0;
      edx_q    <= '0;
      edy_q    <= '0;
      row_e    <= '0;
      cur_e    <= '0;
      dzdx_q   <= '0;
      dzdy_q   <= '0;
      row_z    <= '0;
      cur_z    <= '0;
      meta_q   <= '0;
      cnt      <= '0;
      out_vld  <= 1'b0;
      out_x    <= '0;
      out_y    <= '0;
      out_e    <= '0;
      out_z    <= '0;
      out_meta <= '0;
      done     <= 1'b0;
      px_count <= '0;
    end else begin
      done <= 1'b0;
      if (out_rdy) out_vld <= 1'b0;

      if (flush) begin
        out_vld <= 1'b0;
        state   <= IDLE;
        tri_rdy <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            tri_rdy <= 1'b1;
            if (tri_vld && tri_rdy) begin
              min_x_q <= tri_min_x;
              max_x_q <= tri_max_x;
              max_y_q <= tri_max_y;
              cur_x   <= tri_min_x;
              cur_y   <= tri_min_y;
              edx_q   <= tri_edx;
              edy_q   <= tri_edy;
              row_e   <= tri_e;
              cur_e   <= tri_e;
              dzdx_q  <= tri_dzdx;
              dzdy_q  <= tri_dzdy;
              row_z   <= tri_z;
              cur_z   <= tri_z;
              meta_q  <= tri_meta;
              cnt     <= '0;
              if (empty_box) begin
                done     <= 1'b1;
                px_count <= '0;
              end else begin
                state   <= SCAN;
                tri_rdy <= 1'b0;
              end
            end
          end

          SCAN: begin
            if (slot_free) begin
              // A rejected pixel still consumes the cursor step; the slot stays empty.
              if (issue) begin
                out_vld  <= 1'b1;
                out_x    <= cur_x;
                out_y    <= cur_y;
                out_e    <= cur_e;
                out_z    <= cur_z;
                out_meta <= meta_q;
              end
              cnt <= cnt_inc;
              if (!last_col) begin
                cur_x <= cur_x + XW'(1);
                cur_e <= e_step_x;
                cur_z <= cur_z + dzdx_q;
              end else if (!last_row) begin
                cur_x <= min_x_q;
                cur_y <= cur_y + YW'(1);
                row_e <= e_step_y;
                cur_e <= e_step_y;
                row_z <= row_z + dzdy_q;
                cur_z <= row_z + dzdy_q;
              end else begin
                state    <= IDLE;
                tri_rdy  <= 1'b1;
                done     <= 1'b1;
                px_count <= cnt_inc;
              end
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_raster_scan_ctrl.sv
// Directed self-checking bench for raster_scan_ctrl: scan order, stalls, empty bbox,
// flush, back-to-back acceptance and (when enabled) early reject.
`ifndef FX_TOTAL_BITS
`define FX_TOTAL_BITS 16
`endif

module tb_raster_scan_ctrl;
  localparam int XW = 12;
  localparam int YW = 12;
  localparam int EW = 2*`FX_TOTAL_BITS;
  localparam int ZW = 2*`FX_TOTAL_BITS;
  localparam int MW = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              tri_vld;
  logic              tri_rdy;
  logic [XW-1:0]     tri_min_x, tri_max_x;
  logic [YW-1:0]     tri_min_y, tri_max_y;
  logic [3*EW-1:0]   tri_e, tri_edx, tri_edy;
  logic [ZW-1:0]     tri_z, tri_dzdx, tri_dzdy;
  logic [MW-1:0]     tri_meta;
  logic              out_vld;
  logic              out_rdy;
  logic [XW-1:0]     out_x;
  logic [YW-1:0]     out_y;
  logic [3*EW-1:0]   out_e;
  logic [ZW-1:0]     out_z;
  logic [MW-1:0]     out_meta;
  logic              done;
  logic [XW+YW-1:0]  px_count;

  int n_checks = 0;
  int n_fail   = 0;

  raster_scan_ctrl dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .tri_vld(tri_vld), .tri_rdy(tri_rdy),
    .tri_min_x(tri_min_x), .tri_max_x(tri_max_x),
    .tri_min_y(tri_min_y), .tri_max_y(tri_max_y),
    .tri_e(tri_e), .tri_edx(tri_edx), .tri_edy(tri_edy),
    .tri_z(tri_z), .tri_dzdx(tri_dzdx), .tri_dzdy(tri_dzdy),
    .tri_meta(tri_meta),
    .out_vld(out_vld), .out_rdy(out_rdy),
    .out_x(out_x), .out_y(out_y), .out_e(out_e), .out_z(out_z),
    .out_meta(out_meta), .done(done), .px_count(px_count)
  );

  always #5 clk = ~clk;

  function automatic logic [3*EW-1:0] p3(input logic [EW-1:0] a2, input logic [EW-1:0] a1,
                                         input logic [EW-1:0] a0);
    return {a2, a1, a0};
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_tri(input int minx, input int maxx, input int miny, input int maxy,
                         input logic [3*EW-1:0] e, input logic [3*EW-1:0] edx,
                         input logic [3*EW-1:0] edy, input int z, input int dzx, input int dzy);
    tri_min_x = XW'(minx);
    tri_max_x = XW'(maxx);
    tri_min_y = YW'(miny);
    tri_max_y = YW'(maxy);
    tri_e     = e;
    tri_edx   = edx;
    tri_edy   = edy;
    tri_z     = ZW'(z);
    tri_dzdx  = ZW'(dzx);
    tri_dzdy  = ZW'(dzy);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; flush = 1'b0; tri_vld = 1'b0; out_rdy = 1'b1; tri_meta = '0;
    set_tri(0, 0, 0, 0, '0, '0, '0, 0, 0, 0);
    step; step;
    n_checks++;
    if (tri_rdy !== 1'b0 || out_vld !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: tri_rdy=%b out_vld=%b done=%b required 0 0 0", tri_rdy, out_vld, done);
    end
    n_checks++;
    if (px_count !== '0 || out_x !== '0 || out_y !== '0 || out_e !== '0 || out_z !== '0 || out_meta !== '0) begin
      n_fail++;
      $display("FAIL reset_data: px_count=%0h x=%0h y=%0h z=%0h required all 0", px_count, out_x, out_y, out_z);
    end
    rst_n = 1'b1;
    step;
    n_checks++;
    if (tri_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_rdy: tri_rdy=%b required 1", tri_rdy);
    end
  endtask

  // 2x2 bbox, distinct per-lane gradients; rdy_low_cycles stalls the second pixel.
  task automatic run_2x2(input string tag, input int rdy_low_cycles);
    int ex[4] = '{0, 1, 0, 1};
    int ey[4] = '{0, 0, 1, 1};
    int ez[4] = '{100, 101, 150, 151};
    logic [3*EW-1:0] ee[4];
    ee[0] = p3(300, 200, 0);
    ee[1] = p3(303, 202, 1);
    ee[2] = p3(330, 220, 10);
    ee[3] = p3(333, 222, 11);
    tri_meta = 16'hA5C3;
    set_tri(0, 1, 0, 1, p3(300, 200, 0), p3(3, 2, 1), p3(30, 20, 10), 100, 1, 50);
    tri_vld = 1'b1;
    step;
    tri_vld = 1'b0;
    n_checks++;
    if (tri_rdy !== 1'b0 || out_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_accept: tri_rdy=%b out_vld=%b required 0 0", tag, tri_rdy, out_vld);
    end
    for (int k = 0; k < 4; k++) begin
      step;
      n_checks++;
      if (out_vld !== 1'b1 || out_x !== XW'(ex[k]) || out_y !== YW'(ey[k]) ||
          out_e !== ee[k] || out_z !== ZW'(ez[k]) || out_meta !== 16'hA5C3) begin
        n_fail++;
        $display("FAIL %s_pix%0d: vld=%b x=%0d y=%0d e=%h z=%0d required 1 %0d %0d %h %0d",
                 tag, k, out_vld, out_x, out_y, out_e, out_z, ex[k], ey[k], ee[k], ez[k]);
      end
      n_checks++;
      if (done !== (k == 3)) begin
        n_fail++;
        $display("FAIL %s_done%0d: done=%b required %b", tag, k, done, k == 3);
      end
      if (k == 1 && rdy_low_cycles > 0) begin
        out_rdy = 1'b0;
        for (int s = 0; s < rdy_low_cycles; s++) begin
          step;
          n_checks++;
          if (out_vld !== 1'b1 || out_x !== XW'(1) || out_y !== YW'(0) || out_e !== ee[1] ||
              out_z !== ZW'(101) || done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_hold%0d: vld=%b x=%0d y=%0d z=%0d done=%b required 1 1 0 101 0",
                     tag, s, out_vld, out_x, out_y, out_z, done);
          end
        end
        out_rdy = 1'b1;
      end
    end
    n_checks++;
    if (px_count !== 24'd4 || tri_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_count: px_count=%0d tri_rdy=%b required 4 1", tag, px_count, tri_rdy);
    end
    step;
    n_checks++;
    if (out_vld !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_drain: out_vld=%b done=%b required 0 0", tag, out_vld, done);
    end
  endtask

  task automatic test_basic;
    run_2x2("basic", 0);
  endtask

  task automatic test_stall;
    run_2x2("stall", 3);
  endtask

  task automatic test_flush;
    set_tri(0, 3, 0, 3, p3(0, 0, 0), p3(1, 1, 1), p3(10, 10, 10), 0, 0, 0);
    tri_vld = 1'b1;
    step;
    tri_vld = 1'b0;
    step;
    step;
    n_checks++;
    if (out_vld !== 1'b1 || out_x !== XW'(1) || out_y !== YW'(0)) begin
      n_fail++;
      $display("FAIL flush_pre: vld=%b x=%0d y=%0d required 1 1 0", out_vld, out_x, out_y);
    end
    flush = 1'b1;
    tri_vld = 1'b1;
    step;
    flush = 1'b0;
    tri_vld = 1'b0;
    n_checks++;
    if (out_vld !== 1'b0 || done !== 1'b0 || px_count !== 24'd4 || tri_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_abort: vld=%b done=%b px_count=%0d rdy=%b required 0 0 4 1",
               out_vld, done, px_count, tri_rdy);
    end
    step;
    n_checks++;
    if (out_vld !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_quiet: vld=%b done=%b required 0 0", out_vld, done);
    end
    set_tri(2, 2, 3, 3, p3(7, 6, 5), p3(1, 1, 1), p3(1, 1, 1), 9, 0, 0);
    tri_vld = 1'b1;
    step;
    tri_vld = 1'b0;
    step;
    n_checks++;
    if (out_vld !== 1'b1 || out_x !== XW'(2) || out_y !== YW'(3) || out_e !== p3(7, 6, 5) ||
        out_z !== ZW'(9) || done !== 1'b1 || px_count !== 24'd1) begin
      n_fail++;
      $display("FAIL flush_next: vld=%b x=%0d y=%0d z=%0d done=%b cnt=%0d required 1 2 3 9 1 1",
               out_vld, out_x, out_y, out_z, done, px_count);
    end
    step;
  endtask

  task automatic test_empty;
    set_tri(5, 4, 0, 0, p3(1, 1, 1), p3(1, 1, 1), p3(1, 1, 1), 0, 0, 0);
    tri_vld = 1'b1;
    step;
    tri_vld = 1'b0;
    n_checks++;
    if (done !== 1'b1 || px_count !== '0 || tri_rdy !== 1'b1 || out_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_done: done=%b cnt=%0d rdy=%b vld=%b required 1 0 1 0",
               done, px_count, tri_rdy, out_vld);
    end
    for (int i = 0; i < 3; i++) begin
      step;
      n_checks++;
      if (done !== 1'b0 || out_vld !== 1'b0) begin
        n_fail++;
        $display("FAIL empty_after%0d: done=%b vld=%b required 0 0", i, done, out_vld);
      end
    end
  endtask

  task automatic test_back_to_back;
    int pix = 0;
    int dones = 0;
    set_tri(7, 7, 9, 9, p3(3, 2, 1), '0, '0, 42, 0, 0);
    tri_vld = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step;
      n_checks++;
      if (out_vld !== (c % 2 == 1) || done !== (c % 2 == 1)) begin
        n_fail++;
        $display("FAIL b2b_cycle%0d: vld=%b done=%b required %b %b",
                 c, out_vld, done, c % 2 == 1, c % 2 == 1);
      end
      if (out_vld === 1'b1 && out_x === XW'(7) && out_y === YW'(9)) pix++;
      if (done === 1'b1) dones++;
    end
    tri_vld = 1'b0;
    n_checks++;
    if (pix != 4 || dones != 4 || px_count !== 24'd1) begin
      n_fail++;
      $display("FAIL b2b_totals: pixels=%0d dones=%0d px_count=%0d required 4 4 1", pix, dones, px_count);
    end
    step;
    step;
  endtask

`ifdef RASTER_EARLY_REJECT_EN
  task automatic test_reject;
    logic signed [EW-1:0] m2;
    m2 = -2;
    set_tri(0, 3, 0, 0, p3(5, 5, m2), p3(0, 0, 1), '0, 0, 0, 0);
    tri_vld = 1'b1;
    step;
    tri_vld = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step;
      n_checks++;
      if (out_vld !== (c >= 2) || (c >= 2 && (out_x !== XW'(c) || out_e !== p3(5, 5, EW'(c - 2)))) ||
          done !== (c == 3)) begin
        n_fail++;
        $display("FAIL reject_c%0d: vld=%b x=%0d e=%h done=%b", c, out_vld, out_x, out_e, done);
      end
    end
    n_checks++;
    if (px_count !== 24'd2) begin
      n_fail++;
      $display("FAIL reject_count: px_count=%0d required 2", px_count);
    end
    step;
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_stall;
    test_flush;
    test_empty;
    test_back_to_back;
`ifdef RASTER_EARLY_REJECT_EN
    test_reject;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/raster_scan_ctrl.md
# raster_scan_ctrl

Bounding-box traversal sequencer for the pixel stage. Accepts one triangle setup record (bbox, edge values and edge/depth gradients at the bbox origin) and walks the bbox in row-major order. For each pixel it incrementally updates the three edge functions and depth, then issues the result to `pixel_processor` over a valid/ready handshake at up to one pixel per cycle.

## Interface
Parameters:
- `XW`, 12: pixel x coordinate width (unsigned).
- `YW`, 12: pixel y coordinate width (unsigned).
- `EW`, 2*`FX_TOTAL_BITS`: edge function width (signed, two's complement).
- `ZW`, 2*`FX_TOTAL_BITS`: depth accumulator width (unsigned).
- `MW`, 16: opaque metadata width.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `flush` in 1: synchronous abort of current triangle.
- `tri_vld` in 1: setup record valid.
- `tri_rdy` out 1: controller can accept a setup record.
- `tri_min_x` / `tri_max_x` in XW: inclusive bbox x range.
- `tri_min_y` / `tri_max_y` in YW: inclusive bbox y range.
- `tri_e` in 3*EW: edge values {e2,e1,e0} at (min_x,min_y).
- `tri_edx` in 3*EW: per-column edge increments {e2,e1,e0}.
- `tri_edy` in 3*EW: per-row edge increments {e2,e1,e0}.
- `tri_z`, `tri_dzdx`, `tri_dzdy` in ZW: depth at origin and its gradients.
- `tri_meta` in MW: passed through unchanged with every pixel.
- `out_vld` out 1: pixel record valid.
- `out_rdy` in 1: downstream accepts the pixel record.
- `out_x` out XW, `out_y` out YW: pixel coordinates.
- `out_e` out 3*EW: edge values at the pixel.
- `out_z` out ZW: depth at the pixel.
- `out_meta` out MW: latched `tri_meta`.
- `done` out 1: one-cycle pulse when traversal of a triangle ends.
- `px_count` out XW+YW: pixels issued for the last finished triangle.

## Operation
- FSM states: `IDLE`, `SCAN`.
- `IDLE`: `tri_rdy`=1. A `tri_vld && tri_rdy` handshake latches all `tri_*` inputs, loads the row-start and current accumulators with `tri_e`/`tri_z`, sets cursor (min_x,min_y), clears the counter, and moves to `SCAN`.
- Empty bbox (`min_x>max_x` or `min_y>max_y`): the record is accepted, `done` pulses, `px_count`=0, and the controller stays in `IDLE`.
- `SCAN`: the controller advances the cursor when the output slot is free (`!out_vld || out_rdy`).
  - Current pixel is loaded into the output register. `out_vld`=1 and the counter increments.
  - If `x<max_x`: x+1, e+=edx, z+=dzdx.
  - Else: x=min_x, y+1, row-start e+=edy, row-start z+=dzdy, current accumulators ← new row-start.
  - Final pixel (max_x,max_y): return to `IDLE`, pulse `done` next cycle, latch `px_count`.
- Output register holds all `out_*` stable while `out_vld && !out_rdy`.
- Arithmetic: edges signed add modulo 2^EW; z unsigned add modulo 2^ZW. No saturation. Coordinates never wrap (bbox is inclusive, and the cursor stops at max).
- A new setup record may be accepted while the last pixel of the previous triangle is still held in the output register.
- `flush` (any state): `out_vld`←0, state←`IDLE`, no `done`, `px_count` unchanged. `flush` takes priority over a simultaneous `tri_vld` handshake, which is not accepted.

## Timing
- Reset values: `tri_rdy`=0 (rises the first cycle after release), `out_vld`=0, `done`=0, `px_count`=0, all data outputs 0, state `IDLE`.
- Latency: handshake at edge N means the first `out_vld`=1 after edge N+1.
- Throughput: 1 pixel/cycle with `out_rdy` held high. Each `out_rdy` low cycle stalls the scan one cycle.
- `done`: asserted for exactly one cycle, the cycle after the final pixel is loaded into the output register (independent of its downstream handshake).
- `tri_rdy` is 0 throughout `SCAN` and 1 in the cycle after the final pixel is loaded.

## Configuration
- `RASTER_EARLY_REJECT_EN` defined: pixels with any edge value <0 are not issued. The cursor still advances one pixel per free-slot cycle, and `px_count` counts only issued pixels. If the final pixel is rejected, `done` still pulses on the same schedule.
- Undefined: every bbox pixel is issued, and the inside test is left to `pixel_processor`. `px_count` equals the bbox area.

## Test plan
- bbox (0,0)-(1,1), e=(0,0,0), edx=(1,1,1), edy=(10,10,10), `out_rdy`=1 → pixels (0,0),(1,0),(0,1),(1,1) on consecutive cycles with e0=0,1,10,11. `done` 1 cycle after the 4th pixel, `px_count`=4.
- Same setup, `out_rdy` low for 3 cycles on the 2nd pixel → (1,0) held stable for 3 cycles, no pixel lost or duplicated.
- bbox min_x=5, max_x=4 → accepted, no `out_vld`, `done` pulse, `px_count`=0.
- With `RASTER_EARLY_REJECT_EN`: bbox (0,0)-(3,0), e0=-2, edx0=1, other edges ≥0 → only x=2,3 issued, `px_count`=2.
- `flush` asserted after 2 pixels of a 4x4 bbox → `out_vld` drops next cycle, no `done`. The next record is accepted and scans from its own min corner.
- Back-to-back 1x1 triangles with `tri_vld` held high → one accepted every 2 cycles, each yielding exactly one pixel and one `done`.
